// File: rtl/sfu_pkg.sv
// Shared definitions for the SFU sequencer: FSM state encoding and default
// geometry (lane count, partial-sum width, output-address width).
package sfu_pkg;

    localparam int unsigned COL_DEFAULT     = 8;
    localparam int unsigned PSUM_BW_DEFAULT = 16;
    localparam int unsigned AW_DEFAULT      = 4;
    localparam int unsigned NACC_W          = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ACC   = 3'd2,
        S_RELU  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } sfu_state_e;

endpackage

// File: rtl/sfu_seq.sv
// sfu_seq: sequences one output vector through the SFU lanes.
//   start/mode/n_acc : request, latched when accepted in IDLE
//   in_valid/in_ready/in_data : psum vector stream (accepted only in ACC)
//   sfu_reset/sfu_acc/sfu_relu/sfu_mode/sfu_in/sfu_out : SFU control + data
//   wr_en/wr_addr/wr_data : output-SRAM write port
//   busy/done : status
// Optional feature: define SFU_SEQ_RELU_BYPASS_EN to add the relu_en input;
// a latched relu_en of 0 skips the RELU state.
// sfu_acc, sfu_in and wr_data are combinational so that the SFU sees a beat in
// the same cycle as its handshake; every other output is a flop.
module sfu_seq
    import sfu_pkg::*;
#(
    parameter int unsigned col     = COL_DEFAULT,
    parameter int unsigned psum_bw = PSUM_BW_DEFAULT,
    parameter int unsigned aw      = AW_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     mode,
    input  logic [NACC_W-1:0]        n_acc,
`ifdef SFU_SEQ_RELU_BYPASS_EN
    input  logic                     relu_en,
`endif
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [col*psum_bw-1:0]   in_data,
    output logic                     sfu_reset,
    output logic                     sfu_acc,
    output logic                     sfu_relu,
    output logic                     sfu_mode,
    output logic [col*psum_bw-1:0]   sfu_in,
    input  logic [col*psum_bw-1:0]   sfu_out,
    output logic                     wr_en,
    output logic [aw-1:0]            wr_addr,
    output logic [col*psum_bw-1:0]   wr_data,
    output logic                     busy,
    output logic                     done
);

    sfu_state_e        state;
    logic [NACC_W-1:0] n_acc_q;
    logic [NACC_W-1:0] beat;
    logic [NACC_W-1:0] beat_inc;
    logic              hs;
    logic              use_relu;

    // in_ready is only ever high in ACC, so a handshake implies ACC
    assign hs       = in_valid & in_ready;
    assign beat_inc = NACC_W'(beat + 1'b1);
    assign sfu_acc  = hs;
    assign sfu_in   = hs ? in_data : '0;
    assign wr_data  = wr_en ? sfu_out : '0;

`ifdef SFU_SEQ_RELU_BYPASS_EN
    logic relu_q;
    assign use_relu = relu_q;
`else
    assign use_relu = 1'b1;
`endif

    // FSM with outputs registered for the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_en     <= 1'b0;
            in_ready  <= 1'b0;
            sfu_relu  <= 1'b0;
            sfu_reset <= 1'b1;
            sfu_mode  <= 1'b0;
            n_acc_q   <= '0;
            beat      <= '0;
            wr_addr   <= '0;
`ifdef SFU_SEQ_RELU_BYPASS_EN
            relu_q    <= 1'b0;
`endif
        end else begin
            done      <= 1'b0;
            wr_en     <= 1'b0;
            in_ready  <= 1'b0;
            sfu_relu  <= 1'b0;
            sfu_reset <= 1'b0;
            busy      <= 1'b1;

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        sfu_mode  <= mode;
                        n_acc_q   <= n_acc;
                        beat      <= '0;
`ifdef SFU_SEQ_RELU_BYPASS_EN
                        relu_q    <= relu_en;
`endif
                        sfu_reset <= 1'b1;
                        state     <= S_CLEAR;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                S_CLEAR: begin
                    if (n_acc_q == '0) begin
                        if (use_relu) begin
                            state    <= S_RELU;
                            sfu_relu <= 1'b1;
                        end else begin
                            state <= S_WRITE;
                            wr_en <= 1'b1;
                        end
                    end else begin
                        state    <= S_ACC;
                        in_ready <= 1'b1;
                    end
                end

                // Holds indefinitely until the last beat is handed over
                S_ACC: begin
                    if (hs && (beat_inc == n_acc_q)) begin
                        beat <= beat_inc;
                        if (use_relu) begin
                            state    <= S_RELU;
                            sfu_relu <= 1'b1;
                        end else begin
                            state <= S_WRITE;
                            wr_en <= 1'b1;
                        end
                    end else begin
                        if (hs) begin
                            beat <= beat_inc;
                        end
                        in_ready <= 1'b1;
                    end
                end

                S_RELU: begin
                    state <= S_WRITE;
                    wr_en <= 1'b1;
                end

                // Address wraps naturally at 2^aw
                S_WRITE: begin
                    state   <= S_DONE;
                    done    <= 1'b1;
                    wr_addr <= aw'(wr_addr + 1'b1);
                end

                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sfu_seq.md
SFU_SEQ -- requirements
Module: sfu_seq

Interface
REQ-001 Parameter col, default 8: number of SFU lanes driven in parallel.
REQ-002 Parameter psum_bw, default 16: per-lane partial-sum width in bits.
REQ-003 Parameter aw, default 4: output write-address width.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to process one output vector; sampled only in IDLE.
REQ-007 mode  input  1  0 = 4-bit mode, 1 = 2-bit SIMD mode; latched at accepted start.
REQ-008 n_acc  input  4  number of psum vectors to accumulate (0..15); latched at accepted start.
REQ-009 in_valid  input  1  psum vector available.
REQ-010 in_ready  output  1  sequencer accepts a psum vector.
REQ-011 in_data  input  col*psum_bw  psum vector, lane i at bits [i*psum_bw +: psum_bw].
REQ-012 sfu_reset / sfu_acc / sfu_relu / sfu_mode  output  1 each  SFU control lines.
REQ-013 sfu_in  output  col*psum_bw  data to SFU lanes; sfu_out  input  col*psum_bw  registered SFU results.
REQ-014 wr_en  output  1;  wr_addr  output  aw;  wr_data  output  col*psum_bw: output-SRAM write port.
REQ-015 busy  output  1  high outside IDLE;  done  output  1  one-cycle completion pulse.

Function
REQ-016 FSM states are IDLE, CLEAR, ACC, RELU, WRITE, DONE.
REQ-017 IDLE->CLEAR on start; start outside IDLE is ignored.
REQ-018 CLEAR lasts one cycle with sfu_reset=1; next state is ACC, or RELU when latched n_acc==0.
REQ-019 In ACC: in_ready=1; on in_valid&in_ready, sfu_acc=1 and sfu_in=in_data in the same cycle, and the 4-bit beat counter increments.
REQ-020 In ACC without a handshake: sfu_acc=0 and the state is held, with no timeout.
REQ-021 ACC->RELU on the handshake that makes the beat count equal latched n_acc.
REQ-022 RELU lasts one cycle with sfu_relu=1, sfu_acc=0 and in_ready=0.
REQ-023 WRITE lasts one cycle with wr_en=1, wr_data=sfu_out and wr_addr=current address; the address then increments modulo 2^aw (15 wraps to 0).
REQ-024 DONE lasts one cycle with done=1, then returns to IDLE.
REQ-025 in_ready=0 in every state except ACC.
REQ-026 sfu_mode equals the latched mode throughout the operation; a mode change mid-operation has no effect.
REQ-027 Latency from accepted start to done equals 4 + (number of ACC cycles); minimum is n_acc + 4.
REQ-028 sfu_in is zero whenever sfu_acc=0.
REQ-029 The sequencer performs no arithmetic on data; lane and SIMD-half arithmetic belong to the SFU.

Reset
REQ-030 Reset in any state returns to IDLE within one cycle and aborts the current operation.
REQ-031 Reset values: busy, done, wr_en, in_ready, sfu_acc and sfu_relu are 0; wr_addr, wr_data, sfu_in and the beat counter are 0; sfu_reset is 1.
REQ-032 The latched mode and n_acc reset to 0.

Configuration
REQ-033 With SFU_SEQ_RELU_BYPASS_EN defined: an extra input relu_en (1 bit) is latched at start; when the latched relu_en is 0, the FSM goes ACC->WRITE (and CLEAR->WRITE when n_acc==0) and never asserts sfu_relu.
REQ-034 Without SFU_SEQ_RELU_BYPASS_EN: the relu_en port does not exist and the RELU state is always visited.

Structure
REQ-035 Shared package sfu_pkg holds the FSM state enum and the default constants for col, psum_bw and aw.
REQ-036 The block is one flat module with no sub-module.

Verification
REQ-037 Basic run: n_acc=3, in_valid held high, lanes 5, -2, 4 -> sfu_acc high for 3 cycles, one sfu_relu pulse, wr_en at addr 0, done 7 cycles after start.
REQ-038 Stall: n_acc=2, in_valid low for 5 cycles between beats -> sfu_acc asserts only on handshakes and done is delayed by exactly 5 cycles.
REQ-039 Wrap: 17 back-to-back operations -> wr_addr sequence 0..15, then 0.
REQ-040 Reset mid-run: reset in ACC after 1 of 3 beats -> the next cycle is IDLE with busy=0 and wr_en never asserted; a fresh start then writes addr 0.
REQ-041 Edge cases: n_acc=0 -> CLEAR, RELU, WRITE, DONE with in_ready never high; start asserted while busy is ignored; mode toggled mid-op leaves sfu_mode constant.
REQ-042 Bypass (macro defined, relu_en=0): sfu_relu is never asserted and the latency is n_acc+3.
